// File: rtl/mem_read_cache.sv
// mem_read_cache
//   2-way set-associative, write-through, no-write-allocate data cache between
//   the MEM stage and the SRAM controller. Read hits answer in the same cycle;
//   read misses fetch a 64-bit line; stores always go through to SRAM.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   address, wdata            request address (word aligned) and store data
//   MEM_R_EN, MEM_W_EN        load / store request, held stable while ready=0
//   rdata, ready              load data and request-complete (0 = freeze)
//   sram_address, sram_wdata  address / store data toward the SRAM controller
//   sram_read_en              line read request (registered)
//   sram_write_en             word write request (registered)
//   sram_rdata, sram_ready    returned line and one-cycle done pulse
//
// States
//   IDLE      | serve hits, accept new requests
//   READ_MISS | line fetch in flight, fill victim way on sram_ready
//   WRITE     | write-through in flight, complete on sram_ready

module mem_read_cache #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_read_en,
  output logic        sram_write_en,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int SETS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

  state_t state;

  logic [SETS-1:0] valid0;
  logic [SETS-1:0] valid1;
  logic [SETS-1:0] lru;     // 1 = way0 is least recently used

  logic [TAG_BITS-1:0] tag0  [SETS];
  logic [TAG_BITS-1:0] tag1  [SETS];
  logic [63:0]         data0 [SETS];
  logic [63:0]         data1 [SETS];

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  word_sel;
  logic                  hit0;
  logic                  hit1;
  logic                  hit;
  logic [63:0]           hit_line;
  logic [31:0]           hit_word;
  logic [31:0]           fill_word;
  logic                  victim;

  assign index    = address[3 +: INDEX_BITS];
  assign tag      = address[3+INDEX_BITS +: TAG_BITS];
  assign word_sel = address[2];

  assign hit0 = valid0[index] && (tag0[index] == tag);
  assign hit1 = valid1[index] && (tag1[index] == tag);
  assign hit  = hit0 || hit1;

  assign hit_line  = hit1 ? data1[index] : data0[index];
  assign hit_word  = word_sel ? hit_line[63:32] : hit_line[31:0];
  assign fill_word = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];

  // Invalid way first (way0 preferred), otherwise the LRU way.
  always_comb begin
    if (!valid0[index])      victim = 1'b0;
    else if (!valid1[index]) victim = 1'b1;
    else                     victim = ~lru[index];
  end

  always_comb begin
    ready = 1'b0;
    rdata = 32'h0;
    case (state)
      IDLE: begin
        if (MEM_W_EN) begin
          ready = 1'b0;
        end else if (MEM_R_EN) begin
          ready = hit;
          if (hit) rdata = hit_word;
        end else begin
          ready = 1'b1;
        end
      end
      READ_MISS: begin
        if (sram_ready) begin
          ready = 1'b1;
          rdata = fill_word;
        end
      end
      WRITE: ready = sram_ready;
      default: ready = 1'b0;
    endcase
  end

  // Reads fetch the whole line, writes go out word-addressed.
  assign sram_address = (state == WRITE) ? address : {address[31:3], 3'b000};
  assign sram_wdata   = wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      sram_read_en  <= 1'b0;
      sram_write_en <= 1'b0;
      valid0        <= '0;
      valid1        <= '0;
      lru           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MEM_W_EN) begin
            state         <= WRITE;
            sram_write_en <= 1'b1;
            if (hit0)      lru[index] <= 1'b0;
            else if (hit1) lru[index] <= 1'b1;
          end else if (MEM_R_EN) begin
            if (hit0) begin
              lru[index] <= 1'b0;
            end else if (hit1) begin
              lru[index] <= 1'b1;
            end else begin
              state        <= READ_MISS;
              sram_read_en <= 1'b1;
            end
          end
        end
        READ_MISS: begin
          if (sram_ready) begin
            state        <= IDLE;
            sram_read_en <= 1'b0;
            if (victim) begin
              valid1[index] <= 1'b1;
              lru[index]    <= 1'b1;
            end else begin
              valid0[index] <= 1'b1;
              lru[index]    <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (sram_ready) begin
            state         <= IDLE;
            sram_write_en <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          sram_read_en  <= 1'b0;
          sram_write_en <= 1'b0;
        end
      endcase
    end
  end

  // Tag/data arrays carry no reset; validity alone decides what is cached.
  // rst gating keeps a reset coinciding with an edge from touching them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && MEM_W_EN) begin
        if (hit0) begin
          if (word_sel) data0[index][63:32] <= wdata;
          else          data0[index][31:0]  <= wdata;
        end else if (hit1) begin
          if (word_sel) data1[index][63:32] <= wdata;
          else          data1[index][31:0]  <= wdata;
        end
      end else if (state == READ_MISS && sram_ready) begin
        if (victim) begin
          tag1[index]  <= tag;
          data1[index] <= sram_rdata;
        end else begin
          tag0[index]  <= tag;
          data0[index] <= sram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_read_cache.sv
module tb_mem_read_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_read_en;
  logic        sram_write_en;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  mem_read_cache dut (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- backing memories ----------------
  logic [31:0] ref_mem  [logic [29:0]];   // what loads should return
  logic [31:0] sram_mem [logic [29:0]];   // what the SRAM model holds

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[17:2] ^ 16'h5A3C, ~a[17:2]};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return init_word(a);
  endfunction

  function automatic logic [31:0] sram_rd(input logic [31:0] a);
    if (sram_mem.exists(a[31:2])) return sram_mem[a[31:2]];
    return init_word(a);
  endfunction

  // ---------------- cache presence model: per set, tags in MRU order ----------------
  int mway [64][2];
  int mcnt [64];

  function automatic bit m_hit(input int s, input int t);
    for (int i = 0; i < mcnt[s]; i++) if (mway[s][i] == t) return 1'b1;
    return 1'b0;
  endfunction

  // Make t most recently used; inserting when absent evicts the oldest of two.
  function automatic void m_use(input int s, input int t);
    if (mcnt[s] > 0 && mway[s][0] == t) return;
    mway[s][1] = mway[s][0];
    mway[s][0] = t;
    if (mcnt[s] < 2) mcnt[s]++;
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < 64; s++) mcnt[s] = 0;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        rd;
    logic        rmiss;
    int          stall;
    logic [31:0] data;
  } exp_t;

  exp_t sb [$];

  int          cur_lat = 0;
  logic [31:0] exp_sram_addr;
  logic [31:0] exp_sram_wdata;
  bit          mon_en = 1'b0;

  // ---------------- SRAM model ----------------
  int sram_cnt = 0;
  always @(posedge clk) begin
    #2;
    sram_ready = 1'b0;
    sram_rdata = {$urandom, $urandom};
    if (rst) begin
      sram_cnt = 0;
    end else if (sram_read_en || sram_write_en) begin
      if (sram_cnt >= cur_lat) begin
        sram_cnt   = 0;
        sram_ready = 1'b1;
        if (sram_write_en) begin
          chk("sram_wr_addr", sram_address, exp_sram_addr);
          chk("sram_wr_data", sram_wdata, exp_sram_wdata);
          sram_mem[sram_address[31:2]] = sram_wdata;
        end else begin
          chk("sram_rd_addr", sram_address, exp_sram_addr);
          sram_rdata = {sram_rd(sram_address | 32'h4), sram_rd(sram_address & ~32'h7)};
        end
      end else begin
        sram_cnt++;
      end
    end else begin
      sram_cnt = 0;
    end
  end

  // ---------------- monitor ----------------
  int waitc  = 0;
  bit saw_rd = 1'b0;
  always @(negedge clk) begin
    if (!mon_en || rst) begin
      waitc  = 0;
      saw_rd = 1'b0;
    end else if (MEM_R_EN || MEM_W_EN) begin
      if (sram_read_en) saw_rd = 1'b1;
      if (!ready) begin
        waitc++;
      end else begin
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("stall_cycles", waitc, e.stall);
          chk("sram_read_en_seen", saw_rd, e.rmiss);
          if (e.rd) chk("rdata", rdata, e.data);
        end
        waitc  = 0;
        saw_rd = 1'b0;
      end
    end else begin
      chk("idle_ready", ready, 1);
      chk("idle_rdata", rdata, 0);
      chk("idle_sram_en", {sram_read_en, sram_write_en}, 0);
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [31:0] a, input logic [31:0] wd,
                       input logic r, input logic w, input int lat);
    exp_t e;
    int   s, t;
    bit   h;
    s = int'(a[8:3]);
    t = int'(a[18:9]);
    h = m_hit(s, t);
    e.rd    = r && !w;
    e.rmiss = e.rd && !h;
    e.stall = (e.rd && h) ? 0 : lat + 1;
    e.data  = ref_rd(a);
    if (e.rd) m_use(s, t);
    if (w) begin
      if (h) m_use(s, t);
      ref_mem[a[31:2]] = wd;
    end
    cur_lat        = lat;
    exp_sram_addr  = w ? a : {a[31:3], 3'b000};
    exp_sram_wdata = wd;
    sb.push_back(e);
    address  = a;
    wdata    = wd;
    MEM_R_EN = r;
    MEM_W_EN = w;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ready) break;
    end
    if (!ready) begin
      $display("FAIL timeout: ready stuck at %0b, required 1 for address %0h", ready, a);
      $fatal(1, "request never completed");
    end
    @(posedge clk); #1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    m_clear();
    rst = 1'b1; address = 32'h0; wdata = 32'h0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    sram_ready = 1'b0; sram_rdata = 64'h0;
    ref_mem[30'h100]  = 32'h1111_1111;  sram_mem[30'h100] = 32'h1111_1111;
    ref_mem[30'h101]  = 32'h2222_2222;  sram_mem[30'h101] = 32'h2222_2222;
    #13;
    chk("rst_ready", ready, 1);
    chk("rst_rdata", rdata, 0);
    chk("rst_sram_en", {sram_read_en, sram_write_en}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // cold read miss, then hit on the other word of the line
    issue(32'h0000_0400, 32'h0, 1'b1, 1'b0, 4);
    issue(32'h0000_0404, 32'h0, 1'b1, 1'b0, 2);

    // LRU replacement in set 1: A, B, A, C evicts B
    issue(32'h0000_0208, 32'h0, 1'b1, 1'b0, 1);
    issue(32'h0000_0408, 32'h0, 1'b1, 1'b0, 0);
    issue(32'h0000_0208, 32'h0, 1'b1, 1'b0, 0);
    issue(32'h0000_0608, 32'h0, 1'b1, 1'b0, 2);
    issue(32'h0000_0208, 32'h0, 1'b1, 1'b0, 0);
    issue(32'h0000_0408, 32'h0, 1'b1, 1'b0, 1);

    // store hit updates cached word
    issue(32'h0000_0400, 32'hDEAD_BEEF, 1'b0, 1'b1, 3);
    issue(32'h0000_0400, 32'h0, 1'b1, 1'b0, 0);

    // store miss does not allocate
    issue(32'h0000_0800, 32'hCAFE_F00D, 1'b0, 1'b1, 1);
    issue(32'h0000_0800, 32'h0, 1'b1, 1'b0, 1);

    // simultaneous read+write on a miss takes the write path
    issue(32'h0000_0C10, 32'h1234_5678, 1'b1, 1'b1, 2);
    issue(32'h0000_0C10, 32'h0, 1'b1, 1'b0, 0);
    idle(2);

    // randomized traffic over a few sets and tags to force conflicts
    for (int k = 0; k < 300; k++) begin
      int sel;
      sel = $urandom_range(0, 9);
      a = 32'h0;
      a[18:9] = 10'($urandom_range(0, 3));
      a[8:3]  = 6'($urandom_range(0, 3));
      a[2]    = 1'($urandom_range(0, 1));
      if (sel < 5)      issue(a, $urandom, 1'b1, 1'b0, $urandom_range(0, 3));
      else if (sel < 8) issue(a, $urandom, 1'b0, 1'b1, $urandom_range(0, 3));
      else if (sel < 9) issue(a, $urandom, 1'b1, 1'b1, $urandom_range(0, 3));
      else              idle($urandom_range(1, 3));
    end

    // reset two cycles into a read miss
    idle(1);
    mon_en         = 1'b0;
    cur_lat        = 20;
    exp_sram_addr  = 32'h0007_0400;
    address        = 32'h0007_0400;
    MEM_R_EN       = 1'b1;
    idle(3);
    chk("rm_read_en_before_rst", sram_read_en, 1);
    chk("rm_ready_before_rst", ready, 0);
    #2;
    rst      = 1'b1;
    MEM_R_EN = 1'b0;
    #1;
    chk("rm_rst_read_en", sram_read_en, 0);
    chk("rm_rst_ready", ready, 1);
    chk("rm_rst_write_en", sram_write_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_clear();
    mon_en = 1'b1;
    idle(1);
    issue(32'h0000_0400, 32'h0, 1'b1, 1'b0, 1);
    issue(32'h0007_0400, 32'h0, 1'b1, 1'b0, 0);
    issue(32'h0000_0400, 32'h0, 1'b1, 1'b0, 0);
    idle(3);

    chk("sb_leftover", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
